// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the 5-stage MIPS core that shares its memory bus
//   with an 8237 DMA. It stalls IF/ID for one cycle on a load-use hazard, which
//   forwarding cannot cover. It flushes wrong-path instructions on a taken
//   branch. It hands the bus to the DMA by draining in-flight memory ops,
//   freezing the pipe and raising hlda.
//
// Parameters
//   ADDR_W       register-address width
//   CNT_W        statistics counter width (HAZARD_STATS_EN builds only)
//   RELEASE_CYC  frozen cycles after hold drops, before fetch resumes (>=1)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rs_ID, rt_ID          source registers of the instruction in decode
//   regFileWriteAddr_EX   destination register of the instruction in execute
//   memRead_EX            execute-stage instruction is a load
//   memOp_EX, memOp_MEM   memory op in flight in EX / MEM
//   branchTaken_EX        branch resolved taken in execute
//   hold                  DMA bus request (HRQ)
//   hlda                  registered bus grant to the DMA
//   pcWriteEn             PC load enable
//   ifidWriteEn           IF/ID register enable
//   ifidFlush, idexFlush  insert a bubble into IF/ID, ID/EX
//   pipeFreeze            hold every pipeline register and the PC
//
// Build option
//   HAZARD_STATS_EN : adds the saturating counters stallCount, flushCount and
//                     holdCount. These count load-use stall cycles, taken-branch
//                     flushes and cycles with hlda=1. Only rst_n clears them.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 16,
  parameter int RELEASE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_ID,
  input  logic [ADDR_W-1:0] rt_ID,
  input  logic [ADDR_W-1:0] regFileWriteAddr_EX,
  input  logic              memRead_EX,
  input  logic              memOp_EX,
  input  logic              memOp_MEM,
  input  logic              branchTaken_EX,
  input  logic              hold,
  output logic              hlda,
  output logic              pcWriteEn,
  output logic              ifidWriteEn,
  output logic              ifidFlush,
  output logic              idexFlush,
  output logic              pipeFreeze
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  flushCount,
  output logic [CNT_W-1:0]  holdCount
`endif
);

  localparam int RC_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rel_cnt;
  logic              load_use;
  logic              rel_done;
  logic              mem_idle;

  // r0 is hardwired to zero, so a load targeting it creates no dependency.
  assign load_use = memRead_EX && (regFileWriteAddr_EX != '0) &&
                    ((regFileWriteAddr_EX == rs_ID) || (regFileWriteAddr_EX == rt_ID));
  assign rel_done = (rel_cnt == RC_W'(RELEASE_CYC - 1));
  assign mem_idle = !memOp_EX && !memOp_MEM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      hlda    <= 1'b0;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      // hlda follows the state register, so it can only rise after the drain
      // has observed both EX and MEM free of memory ops.
      hlda    <= (state_nxt == GRANT);
      rel_cnt <= ((state == RELEASE) && (state_nxt == RELEASE)) ? rel_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    pcWriteEn   = 1'b1;
    ifidWriteEn = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    pipeFreeze  = 1'b0;
    case (state)
      RUN: begin
        // A taken branch flushes the stalled instruction anyway, so it wins over load-use.
        if (branchTaken_EX) begin
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end else if (load_use) begin
          pcWriteEn   = 1'b0;
          ifidWriteEn = 1'b0;
          idexFlush   = 1'b1;
        end
        if (hold) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Bubbles into EX keep new memory ops out while older ones retire.
        pcWriteEn   = 1'b0;
        ifidWriteEn = 1'b0;
        idexFlush   = 1'b1;
        ifidFlush   = branchTaken_EX;
        if (!hold)         state_nxt = RUN;
        else if (mem_idle) state_nxt = GRANT;
      end
      GRANT: begin
        pcWriteEn   = 1'b0;
        ifidWriteEn = 1'b0;
        pipeFreeze  = 1'b1;
        if (!hold) state_nxt = RELEASE;
      end
      default: begin
        pcWriteEn   = 1'b0;
        ifidWriteEn = 1'b0;
        pipeFreeze  = 1'b1;
        if (rel_done) state_nxt = hold ? DRAIN : RUN;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic stall_ev;
  assign stall_ev = (state == RUN) && !branchTaken_EX && load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
      flushCount <= '0;
      holdCount  <= '0;
    end else begin
      if (stall_ev  && (stallCount != '1)) stallCount <= stallCount + 1'b1;
      if (ifidFlush && (flushCount != '1)) flushCount <= flushCount + 1'b1;
      if (hlda      && (holdCount  != '1)) holdCount  <= holdCount + 1'b1;
    end
  end
`else
  wire unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int ADDR_W      = 5;
  localparam int CNT_W       = 16;
  localparam int RELEASE_CYC = 1;

  // Output vector order: {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, pipeFreeze, hlda}
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000100;
  localparam logic [5:0] O_BR    = 6'b111100;
  localparam logic [5:0] O_DRAIN = 6'b000100;
  localparam logic [5:0] O_GRANT = 6'b000011;
  localparam logic [5:0] O_REL   = 6'b000010;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] rs_ID = '0, rt_ID = '0, dest = '0;
  logic              memRead_EX = 1'b0, memOp_EX = 1'b0, memOp_MEM = 1'b0;
  logic              branchTaken_EX = 1'b0, hold = 1'b0;
  logic              hlda, pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, pipeFreeze;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  stallCount, flushCount, holdCount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RELEASE_CYC(RELEASE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .regFileWriteAddr_EX(dest), .memRead_EX(memRead_EX), .memOp_EX(memOp_EX),
    .memOp_MEM(memOp_MEM), .branchTaken_EX(branchTaken_EX), .hold(hold),
    .hlda(hlda), .pcWriteEn(pcWriteEn), .ifidWriteEn(ifidWriteEn),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .pipeFreeze(pipeFreeze)
`ifdef HAZARD_STATS_EN
    , .stallCount(stallCount), .flushCount(flushCount), .holdCount(holdCount)
`endif
  );

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] rs, rt, dst;
    logic              mr, br;
    logic [5:0]        exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {pcWriteEn, ifidWriteEn, ifidFlush, idexFlush, pipeFreeze, hlda};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (pc,ifid,ifidFl,idexFl,frz,hlda) t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rs_ID = '0; rt_ID = '0; dest = '0; memRead_EX = 0; memOp_EX = 0;
    memOp_MEM = 0; branchTaken_EX = 0; hold = 0;
  endtask

  // Check the current inputs at the falling edge, then let the rising edge happen.
  task automatic cyc(input string name, input logic [5:0] exp);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, and how many frozen cycles remain after release.
  bit m_draining, m_granted;
  int m_rel_left;

  function automatic logic [5:0] model_out();
    logic lu;
    lu = memRead_EX && dest != 0 && (dest == rs_ID || dest == rt_ID);
    if (m_granted)           return O_GRANT;
    if (m_rel_left > 0)      return O_REL;
    if (m_draining)          return {O_DRAIN[5:4], branchTaken_EX, O_DRAIN[2:0]};
    if (branchTaken_EX)      return O_BR;
    if (lu)                  return O_STALL;
    return O_RUN;
  endfunction

  task automatic model_step();
    if (m_granted) begin
      if (!hold) begin m_granted = 0; m_rel_left = RELEASE_CYC; end
    end else if (m_rel_left > 0) begin
      m_rel_left--;
      if (m_rel_left == 0 && hold) m_draining = 1;
    end else if (m_draining) begin
      if (!hold) m_draining = 0;
      else if (!memOp_EX && !memOp_MEM) begin m_draining = 0; m_granted = 1; end
    end else if (hold) begin
      m_draining = 1;
    end
  endtask

  initial begin
    vecs[0] = '{"lu_rs",     5'd5,  5'd0,  5'd5,  1'b1, 1'b0, O_STALL};
    vecs[1] = '{"lu_dest0",  5'd0,  5'd0,  5'd0,  1'b1, 1'b0, O_RUN};
    vecs[2] = '{"lu_rt",     5'd1,  5'd7,  5'd7,  1'b1, 1'b0, O_STALL};
    vecs[3] = '{"no_load",   5'd5,  5'd5,  5'd5,  1'b0, 1'b0, O_RUN};
    vecs[4] = '{"no_match",  5'd3,  5'd4,  5'd5,  1'b1, 1'b0, O_RUN};
    vecs[5] = '{"br_and_lu", 5'd5,  5'd0,  5'd5,  1'b1, 1'b1, O_BR};
    vecs[6] = '{"br_only",   5'd2,  5'd3,  5'd9,  1'b0, 1'b1, O_BR};
    vecs[7] = '{"lu_r31",    5'd31, 5'd31, 5'd31, 1'b1, 1'b0, O_STALL};

    idle_inputs();
    #3;
    check("reset_state", O_RUN);
`ifdef HAZARD_STATS_EN
    checks++;
    if ({stallCount, flushCount, holdCount} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0", stallCount, flushCount, holdCount);
    end
`endif
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Combinational RUN behaviour, one instruction per cycle.
    for (int i = 0; i < 8; i++) begin
      rs_ID = vecs[i].rs; rt_ID = vecs[i].rt; dest = vecs[i].dst;
      memRead_EX = vecs[i].mr; branchTaken_EX = vecs[i].br;
      cyc(vecs[i].name, vecs[i].exp);
    end
    idle_inputs();
    cyc("after_lu_run", O_RUN);

    // DMA grant with a memory op still in MEM for two cycles.
    hold = 1; memOp_MEM = 1;
    cyc("grant_run", O_RUN);
    cyc("grant_drain1", O_DRAIN);
    memOp_MEM = 0;
    cyc("grant_drain2", O_DRAIN);
    cyc("grant_hold", O_GRANT);
    hold = 0;
    cyc("grant_last", O_GRANT);
    cyc("release", O_REL);
    cyc("release_run", O_RUN);

    // Branch during drain still flushes IF/ID.
    hold = 1; memOp_EX = 1;
    cyc("br_drain_run", O_RUN);
    branchTaken_EX = 1;
    cyc("br_drain", 6'b001100);
    branchTaken_EX = 0;
    // Hold aborted during drain.
    hold = 0;
    cyc("abort_drain", O_DRAIN);
    memOp_EX = 0;
    cyc("abort_run", O_RUN);
    cyc("abort_run2", O_RUN);

    // Hold re-asserted during release goes straight back through drain.
    hold = 1;
    cyc("rh_run", O_RUN);
    cyc("rh_drain", O_DRAIN);
    cyc("rh_grant", O_GRANT);
    hold = 0;
    cyc("rh_grant2", O_GRANT);
    hold = 1;
    cyc("rh_release", O_REL);
    cyc("rh_drain2", O_DRAIN);
    cyc("rh_grant3", O_GRANT);

    // Asynchronous reset while granted.
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    hold = 0;
    #1;
    check("reset_in_grant", O_RUN);
`ifdef HAZARD_STATS_EN
    checks++;
    if ({stallCount, flushCount, holdCount} !== '0) begin
      errors++; $display("FAIL grant_reset_counters: got %0d/%0d/%0d want 0", stallCount, flushCount, holdCount);
    end
`endif
    #3 rst_n = 1;
    @(posedge clk); #1;
    cyc("post_reset_run", O_RUN);

    // Randomized traffic against the reference model.
    do_reset();
    m_draining = 0; m_granted = 0; m_rel_left = 0;
    for (int n = 0; n < 600; n++) begin
      rs_ID = ADDR_W'($urandom_range(0, 7));
      rt_ID = ADDR_W'($urandom_range(0, 7));
      dest  = ADDR_W'($urandom_range(0, 7));
      memRead_EX     = ($urandom_range(0, 2) == 0);
      memOp_EX       = ($urandom_range(0, 2) == 0);
      memOp_MEM      = ($urandom_range(0, 2) == 0);
      branchTaken_EX = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) hold = ~hold;
      @(negedge clk);
      check("random", {model_out()[5:1], m_granted});
      @(posedge clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
